risc_mem_bridge: RTL

Parametrised memory bridge between the RISC core's load/store unit and a synchronous single-port RAM with memory-mapped switch/LED I/O. It replaces the core's fixed single-cycle `mem_addr`/`w` path with a registered request/ready handshake and a configurable RAM read latency. It decodes I/O addresses and flags protocol errors.

---
 rtl/risc_mem_bridge.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/risc_mem_bridge.sv
// Registered request/ready bridge from the RISC load/store unit to a single-port RAM with switch/LED I/O.
// Optional RISC_MEM_BRIDGE_WBUF_EN posts RAM writes (IDLE->RESP, ram_we high during RESP).
module risc_mem_bridge #(
  parameter int          data_width  = 16,
  parameter int          addr_width  = 9,
  parameter int          rd_latency  = 1,
  parameter int unsigned io_led_addr = 32'h100,
  parameter int unsigned io_sw_addr  = 32'h140
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            cpu_cmd,
  input  logic [addr_width-1:0] cpu_addr,
  input  logic [data_width-1:0] cpu_wdata,
  output logic [data_width-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  output logic                  ram_we,
  input  logic [data_width-1:0] ram_dout,
  input  logic [7:0]            sw,
  output logic [7:0]            led,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR      = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_RSVD  = 2'b11;

  localparam logic [addr_width-1:0] LED_ADDR = io_led_addr[addr_width-1:0];
  localparam logic [addr_width-1:0] SW_ADDR  = io_sw_addr[addr_width-1:0];
  localparam logic [2:0]            LAT      = 3'(rd_latency);

  state_t                r_state;
  logic [2:0]            r_cnt;
  logic [data_width-1:0] r_rdata;
  logic                  r_ready;
  logic [addr_width-1:0] r_ram_addr;
  logic [data_width-1:0] r_ram_din;
  logic                  r_ram_we;
  logic [7:0]            r_led;
  logic                  r_err;

  logic w_is_led;
  logic w_is_sw;

  assign w_is_led = (cpu_addr == LED_ADDR);
  assign w_is_sw  = (cpu_addr == SW_ADDR);

  // Bridge FSM; every output comes straight from a register here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_rdata    <= '0;
      r_ready    <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_we   <= 1'b0;
      r_led      <= 8'd0;
      r_err      <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          case (cpu_cmd)
            CMD_READ: begin
              if (w_is_sw) begin
                r_rdata <= data_width'(sw);
                r_ready <= 1'b1;
                r_state <= S_RESP;
              end else if (w_is_led) begin
                r_rdata <= '0;
                r_ready <= 1'b1;
                r_state <= S_RESP;
              end else begin
                r_ram_addr <= cpu_addr;
                r_cnt      <= LAT;
                r_state    <= S_RD_WAIT;
              end
            end
            CMD_WRITE: begin
              if (w_is_led) begin
                r_led   <= cpu_wdata[7:0];
                r_ready <= 1'b1;
                r_state <= S_RESP;
              end else if (w_is_sw) begin
                r_rdata <= '0;
                r_ready <= 1'b1;
                r_state <= S_RESP;
              end else begin
                r_ram_addr <= cpu_addr;
                r_ram_din  <= cpu_wdata;
                r_ram_we   <= 1'b1;
`ifdef RISC_MEM_BRIDGE_WBUF_EN
                r_ready    <= 1'b1;
                r_state    <= S_RESP;
`else
                r_state    <= S_WR;
`endif
              end
            end
            CMD_RSVD: begin
              r_err   <= 1'b1;
              r_ready <= 1'b1;
              r_state <= S_RESP;
            end
            CMD_NONE: r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
          endcase
        end
        // The counter runs down to zero and then one more edge passes, so ram_dout has settled before capture.
        S_RD_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_rdata <= ram_dout;
            r_ready <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_WR: begin
          r_ram_we <= 1'b0;
          r_ready  <= 1'b1;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          r_ram_we <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_rdata = r_rdata;
  assign cpu_ready = r_ready;
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;
  assign ram_we    = r_ram_we;
  assign led       = r_led;
  assign err       = r_err;

endmodule
